// File: rtl/parking_lot_ctrl.sv
// Two-gate parking lot controller: round-robin entry barrier FSM with open timeout,
// plus a saturating occupancy counter with a sticky error flag.
module parking_lot_ctrl #(
    parameter int CAPACITY = 25,
    parameter int CNT_W    = 5,
    parameter int TIMEOUT  = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_a,
    input  logic             enter_b,
    input  logic             exit_a,
    input  logic             exit_b,
    input  logic             req_a,
    input  logic             req_b,
    output logic             gate_a,
    output logic             gate_b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OPEN_A, OPEN_B} state_e;

    state_e           state_q;
    logic             gate_a_q;
    logic             gate_b_q;
    logic [TMR_W-1:0] timer_q;
    logic             prio_b_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             err_q;
    logic             err_d;
    logic             err_set;
    logic [1:0]       n_in;
    logic [1:0]       n_out;
    logic             tmo_hit;

    // Returns {overflow_or_underflow, clamped_count}.
    function automatic logic [CNT_W:0] sat_count(input logic [CNT_W-1:0] cur,
                                                 input logic [1:0]       ins,
                                                 input logic [1:0]       outs);
        logic signed [CNT_W+1:0] sum;
        logic        [CNT_W:0]   res;
        sum = $signed({2'b00, cur}) + $signed({{CNT_W{1'b0}}, ins})
            - $signed({{CNT_W{1'b0}}, outs});
        if (sum[CNT_W+1]) begin
            res = {1'b1, {CNT_W{1'b0}}};
        end else if (sum > $signed({2'b00, CAP_C})) begin
            res = {1'b1, CAP_C};
        end else begin
            res = {1'b0, sum[CNT_W-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        n_in               = {1'b0, enter_a} + {1'b0, enter_b};
        n_out              = {1'b0, exit_a} + {1'b0, exit_b};
        {err_set, count_d} = sat_count(count_q, n_in, n_out);
        err_d              = err_q | err_set;
    end

    assign full    = (count_q == CAP_C);
    assign empty   = (count_q == '0);
    assign tmo_hit = (timer_q == TMR_LAST);
    assign count   = count_q;
    assign err     = err_q;
    assign gate_a  = gate_a_q;
    assign gate_b  = gate_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            timer_q  <= '0;
            prio_b_q <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            case (state_q)
                IDLE: begin
                    if (!full && (req_a || req_b)) begin
                        timer_q <= '0;
                        // prio_b_q names the gate that wins when both cars wait.
                        if (req_a && (!req_b || !prio_b_q)) begin
                            state_q  <= OPEN_A;
                            gate_a_q <= 1'b1;
                            prio_b_q <= 1'b1;
                        end else begin
                            state_q  <= OPEN_B;
                            gate_b_q <= 1'b1;
                            prio_b_q <= 1'b0;
                        end
                    end
                end
                OPEN_A: begin
                    if (enter_a || tmo_hit || full) begin
                        state_q  <= IDLE;
                        gate_a_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                OPEN_B: begin
                    if (enter_b || tmo_hit || full) begin
                        state_q  <= IDLE;
                        gate_b_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/parking_lot_ctrl.md
PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 25, giving the maximum number of cars in the lot.
REQ-002 The block SHALL have parameter CNT_W, default 5, giving the count width; it SHALL satisfy 2**CNT_W > CAPACITY.
REQ-003 The block SHALL have parameter TIMEOUT, default 200, giving the maximum number of cycles an entry gate stays open.
REQ-004 The block SHALL have input clk, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have inputs enter_a and enter_b, 1 bit each: one-cycle pulses from the gate A and gate B car detectors when a car has fully entered.
REQ-007 The block SHALL have inputs exit_a and exit_b, 1 bit each: one-cycle pulses from the gate A and gate B car detectors when a car has fully exited.
REQ-008 The block SHALL have inputs req_a and req_b, 1 bit each: level signals meaning a car is waiting at that entry barrier.
REQ-009 The block SHALL have outputs gate_a and gate_b, 1 bit each: registered, 1 = barrier open.
REQ-010 The block SHALL have output count, CNT_W bits: registered occupancy.
REQ-011 The block SHALL have outputs full and empty, 1 bit each: full = (count == CAPACITY), empty = (count == 0), decoded from the registered count.
REQ-012 The block SHALL have output err, 1 bit: registered, sticky count-violation flag.

Function
REQ-013 The gate FSM SHALL have three states: IDLE, OPEN_A and OPEN_B; gate_a = (state == OPEN_A) and gate_b = (state == OPEN_B); at most one gate is ever open.
REQ-014 In IDLE with full = 0, the FSM SHALL move to OPEN_A if only req_a is high, to OPEN_B if only req_b is high, and to the gate named by the priority bit if both are high.
REQ-015 In IDLE with full = 1, or with neither request high, the FSM SHALL stay in IDLE.
REQ-016 Gate latency: a request sampled high at edge N SHALL give gate high in the cycle after edge N (one-cycle latency).
REQ-017 The FSM SHALL leave OPEN_x for IDLE at the next edge when any of these holds: enter_x = 1; the timer equals TIMEOUT-1; full = 1.
REQ-018 The FSM SHALL NOT go directly from OPEN_A to OPEN_B, or from OPEN_B to OPEN_A; it always passes through IDLE for at least one cycle.
REQ-019 The timer SHALL clear on entry to an OPEN state and increment each cycle in that state, so a gate is open for at most TIMEOUT cycles.
REQ-020 The priority bit SHALL point at the gate not most recently opened, updating when an OPEN state is entered, giving round-robin arbitration under contention.
REQ-021 Every cycle, count SHALL become count + (enter_a + enter_b) - (exit_a + exit_b), computed at CNT_W+2 signed width.
REQ-022 Enter pulses SHALL be counted whether or not the corresponding gate is open (tailgating is counted).
REQ-023 Simultaneous enter and exit pulses on any gates SHALL net out in the same cycle; for example, enter_a with exit_b leaves count unchanged.
REQ-024 If the unclamped result is above CAPACITY, count SHALL saturate at CAPACITY and err SHALL be set.
REQ-025 If the unclamped result is below 0, count SHALL saturate at 0 and err SHALL be set.
REQ-026 Once set, err SHALL hold until reset.
REQ-027 An enter_x pulse in the same cycle as timeout SHALL both close the gate and be counted.

Reset
REQ-028 When reset is sampled high, the block SHALL at the next edge force: state = IDLE, gate_a = gate_b = 0, count = 0, err = 0, timer = 0, priority = A.
REQ-029 Reset SHALL override all pulses and requests sampled in the same cycle.
REQ-030 Reset asserted while a gate is open SHALL close it at the next edge.
REQ-031 After reset, empty SHALL be 1 and full SHALL be 0.

Verification
REQ-032 The bench SHALL cover simple entry: reset, req_a = 1 at cycle 0 -> gate_a = 1 at cycle 1; enter_a pulse at cycle 5 -> gate_a = 0 and count = 1 at cycle 6.
REQ-033 The bench SHALL cover contention: req_a = req_b = 1 held, enter pulse issued each time a gate opens -> gate order A, B, A, B with at least one IDLE cycle between grants.
REQ-034 The bench SHALL cover timeout: TIMEOUT = 4, req_b held, no enter -> gate_b high for exactly 4 cycles, then low for at least 1 cycle; count unchanged.
REQ-035 The bench SHALL cover the full condition: CAPACITY = 3, three entries -> full = 1; req_a = 1 -> gate_a stays 0; exit_b pulse -> count = 2, full = 0, gate_a = 1 one cycle later.
REQ-036 The bench SHALL cover saturation: count = 0, exit_a pulse -> count = 0, err = 1. Count = CAPACITY, then enter_a + enter_b in the same cycle -> count = CAPACITY, err stays 1 until reset.
REQ-037 The bench SHALL cover reset mid-operation: gate_a open with count = 2, reset for 1 cycle -> gate_a = 0, count = 0, err = 0, empty = 1 next cycle.
